// File: rtl/dl166_pkg.sv
// rtl/dl166_pkg.sv - shared types and constants for the DL166 run controller
// Purpose: controller state encoding, program memory geometry, and the JMP opcode
//          used to park the core.
// Contents: state_t, JMP_OP, PROG_DEPTH, PROG_AW, jmp_self().
package dl166_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [3:0] JMP_OP     = 4'b1001;
    localparam int         PROG_DEPTH = 16;
    localparam int         PROG_AW    = 4;

    // "JMP self": the core re-fetches the same PC, leaves c_flag alone and
    // writes no register, which is how the core is held still.
    function automatic logic [7:0] jmp_self(input logic [PROG_AW-1:0] adr);
        return {JMP_OP, adr};
    endfunction

endpackage

// File: rtl/dl166_prog_mem.sv
// rtl/dl166_prog_mem.sv - 16x8 program memory, sync write, async read
// Purpose: holds the DL166 program; every word returns to PROG_INIT on reset.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset (refills memory)
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational)
module dl166_prog_mem
    import dl166_pkg::*;
#(
    parameter logic [7:0] PROG_INIT = 8'h90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [PROG_AW-1:0] i_waddr,
    input  logic [7:0]         i_wdata,
    input  logic [PROG_AW-1:0] i_raddr,
    output logic [7:0]         o_rdata
);

    logic [7:0] r_mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                r_mem[i] <= PROG_INIT;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dl166_run_ctrl.sv
// rtl/dl166_run_ctrl.sv - run/halt/step/load controller for the DL166 4-bit core
// Purpose: owns program memory, feeds the core its instruction from its PC, loads
//          programs from a byte stream and sequences run, halt and single-step.
// Optional feature macro: DL166_BREAKPOINT_EN (adds bp_en, bp_addr, bp_hit).
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   cpu_adr / cpu_dout         core PC in, instruction out
//   cpu_reset                  core reset (active-low)
//   ld_start/valid/data/last   program load stream; ld_ready out
//   cmd_run/halt/step          control pulses
//   running, step_done         status
//   cyc_cnt                    saturating executed-instruction count
module dl166_run_ctrl
    import dl166_pkg::*;
#(
    parameter int         CYC_W     = 16,
    parameter logic [7:0] PROG_INIT = 8'h90
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cpu_adr,
    output logic [7:0]       cpu_dout,
    output logic             cpu_reset,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    output logic             ld_ready,
    input  logic             ld_last,
    input  logic             cmd_run,
    input  logic             cmd_halt,
    input  logic             cmd_step,
    output logic             running,
    output logic             step_done,
    output logic [CYC_W-1:0] cyc_cnt
`ifdef DL166_BREAKPOINT_EN
    ,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    output logic             bp_hit
`endif
);

    localparam logic [CYC_W-1:0] CYC_ONE = 1;

    state_t             r_state;
    state_t             w_next;
    logic [PROG_AW-1:0] r_ptr;
    logic               r_cpu_resetn;
    logic               r_step_done;
    logic [CYC_W-1:0]   r_cyc_cnt;
    logic               w_bp_match;
    logic               w_wr;
    logic               w_exec;
    logic               w_core_rst;
    logic [7:0]         w_mem_rdata;

`ifdef DL166_BREAKPOINT_EN
    logic r_bp_hit;

    assign w_bp_match = (r_state == ST_RUN) && bp_en && (cpu_adr == bp_addr);
    assign bp_hit     = r_bp_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= w_bp_match;
        end
    end
`else
    assign w_bp_match = 1'b0;
`endif

    dl166_prog_mem #(
        .PROG_INIT (PROG_INIT)
    ) u_prog_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr),
        .i_waddr (r_ptr),
        .i_wdata (ld_data),
        .i_raddr (cpu_adr),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (ld_start) begin
                    w_next = ST_LOAD;
                end else if (cmd_step) begin
                    w_next = ST_STEP;
                end else if (cmd_run) begin
                    w_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                // Pointer at 15 means this byte is the 16th: the load ends here.
                if (ld_valid && (ld_last || (r_ptr == 4'd15))) begin
                    w_next = ST_HALT;
                end
            end
            ST_RUN: begin
                if (w_bp_match || cmd_halt) begin
                    w_next = ST_HALT;
                end
            end
            ST_STEP: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_HALT;
            end
        endcase
    end

    assign w_wr   = (r_state == ST_LOAD) && ld_valid;
    // A breakpoint cycle presents JMP self, so nothing is executed that cycle.
    assign w_exec = ((r_state == ST_RUN) && !w_bp_match) || (r_state == ST_STEP);
    // Core held in reset while loading; registering this gives the extra cycle after LOAD.
    assign w_core_rst = (r_state == ST_LOAD) || (w_next == ST_LOAD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_HALT;
            r_ptr        <= '0;
            r_cpu_resetn <= 1'b0;
            r_step_done  <= 1'b0;
            r_cyc_cnt    <= '0;
        end else begin
            r_state      <= w_next;
            r_cpu_resetn <= !w_core_rst;
            r_step_done  <= (r_state == ST_STEP);
            if ((r_state == ST_HALT) && ld_start) begin
                r_ptr <= '0;
            end else if (w_wr) begin
                r_ptr <= r_ptr + 4'd1;
            end
            if (w_core_rst) begin
                r_cyc_cnt <= '0;
            end else if (w_exec && (r_cyc_cnt != '1)) begin
                r_cyc_cnt <= r_cyc_cnt + CYC_ONE;
            end
        end
    end

    assign cpu_dout  = w_exec ? w_mem_rdata : jmp_self(cpu_adr);
    assign cpu_reset = r_cpu_resetn;
    assign ld_ready  = (r_state == ST_LOAD);
    assign running   = (r_state == ST_RUN);
    assign step_done = r_step_done;
    assign cyc_cnt   = r_cyc_cnt;

endmodule

// File: tb/tb_dl166_run_ctrl.sv
// tb/tb_dl166_run_ctrl.sv - self-checking bench for dl166_run_ctrl
module tb_dl166_run_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  cpu_adr;
    logic [7:0]  cpu_dout;
    logic        cpu_reset;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_last;
    logic        cmd_run;
    logic        cmd_halt;
    logic        cmd_step;
    logic        running;
    logic        step_done;
    logic [15:0] cyc_cnt;
`ifdef DL166_BREAKPOINT_EN
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic        bp_hit;
`endif

    int total = 0;
    int bad   = 0;
    int steps_seen = 0;
    int steps_exp  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] prev_dout;

    // Tiny stand-in for the core: JMP (9x), MVI r0 (Ax), INC r0 (6x), others advance PC.
    logic [3:0] pc;
    logic [7:0] r0;

    dl166_run_ctrl #(.CYC_W(16), .PROG_INIT(8'h90)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_adr   (cpu_adr),
        .cpu_dout  (cpu_dout),
        .cpu_reset (cpu_reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_last   (ld_last),
        .cmd_run   (cmd_run),
        .cmd_halt  (cmd_halt),
        .cmd_step  (cmd_step),
        .running   (running),
        .step_done (step_done),
        .cyc_cnt   (cyc_cnt)
`ifdef DL166_BREAKPOINT_EN
        ,
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .bp_hit    (bp_hit)
`endif
    );

    assign cpu_adr = pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cpu_reset) begin
            pc <= 4'd0;
            r0 <= 8'd0;
        end else begin
            case (cpu_dout[7:4])
                4'h9: pc <= cpu_dout[3:0];
                4'hA: begin r0 <= {4'h0, cpu_dout[3:0]}; pc <= pc + 4'd1; end
                4'h6: begin r0 <= r0 + 8'd1; pc <= pc + 4'd1; end
                default: pc <= pc + 4'd1;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: the instruction presented in the STEP cycle is compared when step_done appears.
    always @(negedge clk) begin
        if (step_done === 1'b1) begin
            steps_seen++;
            if (exp_q.size() == 0) begin
                check("step_unexpected", 32'd1, 32'd0);
            end else begin
                check("step_instr", {24'd0, prev_dout}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_dout <= cpu_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [7:0] exp_instr, input logic with_run);
        exp_q.push_back(exp_instr);
        steps_exp++;
        cmd_step = 1'b1;
        cmd_run  = with_run;
        tick();
        cmd_step = 1'b0;
        cmd_run  = 1'b0;
        check("step_not_running", {31'd0, running}, 32'd0);
        tick();
        check("step_done", {31'd0, step_done}, 32'd1);
    endtask

    task automatic pulse_run();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic load_prog3();
        start_load();
        ld_valid = 1'b1; ld_data = 8'hA5; tick();
        ld_data = 8'h60; tick();
        ld_data = 8'h90; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        int lows;
        int acc;
        bit found;
        reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
`ifdef DL166_BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 4'd0;
`endif
        tick(); tick();
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("rst_running",   {31'd0, running},   32'd0);
        check("rst_step_done", {31'd0, step_done}, 32'd0);
        check("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
        check("rst_cyc_cnt",   {16'd0, cyc_cnt},   32'd0);
        check("rst_dout",      {24'd0, cpu_dout},  32'h90);
        reset = 1'b1;
        tick();
        check("rel_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // 1: run the default fill (JMP 0) - PC parks at 0, counter runs
        pulse_run();
        check("t1_running", {31'd0, running}, 32'd1);
        check("t1_cyc0", {16'd0, cyc_cnt}, 32'd0);
        repeat (5) tick();
        check("t1_cyc5", {16'd0, cyc_cnt}, 32'd5);
        check("t1_dout", {24'd0, cpu_dout}, 32'h90);
        check("t1_pc", {28'd0, pc}, 32'd0);
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        check("t1_halted", {31'd0, running}, 32'd0);
        check("t1_cyc6", {16'd0, cyc_cnt}, 32'd6);

        // 2: load MVI 5 / INC r0 / JMP 0
        lows = 0;
        start_load();
        if (!cpu_reset) lows++;
        check("t2_ld_ready", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b1; ld_data = 8'hA5; tick(); if (!cpu_reset) lows++;
        ld_data = 8'h60; tick(); if (!cpu_reset) lows++;
        ld_data = 8'h90; ld_last = 1'b1; tick(); if (!cpu_reset) lows++;
        ld_valid = 1'b0; ld_last = 1'b0;
        check("t2_ready_drop", {31'd0, ld_ready}, 32'd0);
        tick(); if (!cpu_reset) lows++;
        check("t2_reset_lows", lows, 32'd4);
        check("t2_cyc_clr", {16'd0, cyc_cnt}, 32'd0);

        // 3: single-step through the program
        do_step(8'hA5, 1'b0);
        check("t3_pc1", {28'd0, pc}, 32'd1);
        check("t3_r0_5", {24'd0, r0}, 32'd5);
        do_step(8'h60, 1'b0);
        check("t3_pc2", {28'd0, pc}, 32'd2);
        check("t3_r0_6", {24'd0, r0}, 32'd6);
        do_step(8'h90, 1'b0);
        check("t3_pc0", {28'd0, pc}, 32'd0);
        check("t3_cyc3", {16'd0, cyc_cnt}, 32'd3);

        // 4: run, halt sampled on the 10th RUN edge
        pulse_run();
        repeat (9) tick();
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        check("t4_cyc13", {16'd0, cyc_cnt}, 32'd13);
        check("t4_pc", {28'd0, pc}, 32'd1);
        check("t4_r0", {24'd0, r0}, 32'd5);
        for (int i = 0; i < 20; i++) begin
            cmd_halt = (i == 3);
            tick();
            check("t4_frozen_pc", {28'd0, pc}, 32'd1);
        end
        cmd_halt = 1'b0;
        check("t4_frozen_r0", {24'd0, r0}, 32'd5);
        check("t4_frozen_cyc", {16'd0, cyc_cnt}, 32'd13);

        // 5: 17 bytes without ld_last - only 16 accepted
        acc = 0;
        start_load();
        for (int i = 0; i < 17; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h20 + 8'(i);
            if (ld_ready) acc++;
            tick();
        end
        ld_valid = 1'b0;
        check("t5_accepted", acc, 32'd16);
        check("t5_ready_low", {31'd0, ld_ready}, 32'd0);
        tick();
        check("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            do_step(8'h20 + 8'(i), i == 0);
        end
        check("t5_cyc16", {16'd0, cyc_cnt}, 32'd16);

`ifdef DL166_BREAKPOINT_EN
        // 6: breakpoint at address 1, step off it, then reset during RUN
        load_prog3();
        tick();
        bp_en = 1'b1; bp_addr = 4'd1;
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bp_hit) found = 1'b1;
        end
        check("t6_bp_seen", {31'd0, found}, 32'd1);
        check("t6_pc1", {28'd0, pc}, 32'd1);
        check("t6_halted", {31'd0, running}, 32'd0);
        check("t6_cyc1", {16'd0, cyc_cnt}, 32'd1);
        check("t6_dout", {24'd0, cpu_dout}, 32'h91);
        tick();
        check("t6_bp_pulse", {31'd0, bp_hit}, 32'd0);
        do_step(8'h60, 1'b0);
        check("t6_pc2", {28'd0, pc}, 32'd2);
        check("t6_r0", {24'd0, r0}, 32'd6);
        bp_en = 1'b0;
        pulse_run();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("t6_rst_halt", {31'd0, running}, 32'd0);
        tick();
        check("t6_rst_cpu", {31'd0, cpu_reset}, 32'd0);
        reset = 1'b1;
        tick();
        do_step(8'h90, 1'b0);
        check("t6_refill_pc", {28'd0, pc}, 32'd0);
        check("t6_cyc_after", {16'd0, cyc_cnt}, 32'd1);
`endif

        tick(); tick();
        check("sb_steps", steps_seen, steps_exp);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
